// File: rtl/bp_be_acc_mem_fwd_arbiter.sv
// Two-requester arbiter for the accelerator's BedRock memory forward/reverse
// channel pair. Forward messages are granted round-robin at message
// granularity and locked until their last beat; an issue-order FIFO routes
// the in-order reverse responses back to the requester that sent each one.
// Header widths and the size-field position are normally derived from the
// processor configuration; here they are plain parameters.
module bp_be_acc_mem_fwd_arbiter #(
  parameter int credits_p               = 8,
  parameter int mem_fwd_header_width_lp = 64,
  parameter int mem_rev_header_width_lp = 64,
  parameter int bedrock_fill_width_p    = 64,
  parameter int fwd_size_lsb_p          = 0,
  parameter int rev_size_lsb_p          = 0
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [2*mem_fwd_header_width_lp-1:0] req_header_i,
  input  logic [2*bedrock_fill_width_p-1:0]    req_data_i,
  input  logic [1:0]                           req_v_i,
  output logic [1:0]                           req_ready_and_o,
  output logic [mem_fwd_header_width_lp-1:0]   mem_fwd_header_o,
  output logic [bedrock_fill_width_p-1:0]      mem_fwd_data_o,
  output logic                                 mem_fwd_v_o,
  input  logic                                 mem_fwd_ready_and_i,
  input  logic [mem_rev_header_width_lp-1:0]   mem_rev_header_i,
  input  logic [bedrock_fill_width_p-1:0]      mem_rev_data_i,
  input  logic                                 mem_rev_v_i,
  output logic                                 mem_rev_ready_and_o,
  output logic [2*mem_rev_header_width_lp-1:0] rsp_header_o,
  output logic [2*bedrock_fill_width_p-1:0]    rsp_data_o,
  output logic [1:0]                           rsp_v_o,
  input  logic [1:0]                           rsp_ready_and_i,
  output logic                                 busy_o
);

  localparam int FW = mem_fwd_header_width_lp;
  localparam int RW = mem_rev_header_width_lp;
  localparam int CW = $clog2(credits_p + 1);
  localparam int PW = (credits_p > 1) ? $clog2(credits_p) : 1;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  // Index of the final beat for a message of 2^size bytes (at least one beat).
  function automatic logic [4:0] last_beat(input logic [2:0] size);
    int beats;
    beats = (8 << size) / bedrock_fill_width_p;
    if (beats == 0) beats = 1;
    return 5'(beats - 1);
  endfunction

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [4:0]      fwd_cnt_q, fwd_cnt_d;
  logic [4:0]      rev_cnt_q, rev_cnt_d;
  logic [CW-1:0]   credits_used_q, credits_used_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [credits_p-1:0] order_q;

  logic            credit_avail, fwd_en, winner, sel, fwd_hs, fwd_last, grant;
  logic            fifo_v, head, rev_hs, rev_last, complete;
  logic [FW-1:0]   fwd_hdr;

  // Forward selection and pass-through muxing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    credit_avail    = credits_used_q < CW'(credits_p);
    fwd_en          = (state_q == LOCK) | credit_avail;
    winner          = (req_v_i[0] & req_v_i[1]) ? rr_ptr_q : req_v_i[1];
    sel             = (state_q == LOCK) ? owner_q : winner;
    fwd_hdr         = sel ? req_header_i[2*FW-1:FW] : req_header_i[FW-1:0];
    mem_fwd_header_o = fwd_hdr;
    mem_fwd_data_o  = sel ? req_data_i[2*bedrock_fill_width_p-1:bedrock_fill_width_p]
                          : req_data_i[bedrock_fill_width_p-1:0];
    mem_fwd_v_o     = reset_n_i & req_v_i[sel] & fwd_en;
    req_ready_and_o = 2'b00;
    req_ready_and_o[sel] = reset_n_i & fwd_en & mem_fwd_ready_and_i;
    fwd_hs          = mem_fwd_v_o & mem_fwd_ready_and_i;
    fwd_last        = fwd_cnt_q == last_beat(fwd_hdr[fwd_size_lsb_p +: 3]);
  end

  // Forward FSM: grant in IDLE, hold ownership in LOCK until the last beat.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    fwd_cnt_d = fwd_cnt_q;
    grant     = 1'b0;
    if (fwd_hs) begin
      if (state_q == IDLE) begin
        grant    = 1'b1;
        owner_d  = winner;
        rr_ptr_d = ~winner;
        if (!fwd_last) begin
          state_d   = LOCK;
          fwd_cnt_d = 5'd1;
        end
      end else if (fwd_last) begin
        state_d   = IDLE;
        fwd_cnt_d = '0;
      end else begin
        fwd_cnt_d = fwd_cnt_q + 5'd1;
      end
    end
  end

  // Reverse routing from the order FIFO head, credit and pointer bookkeeping.
  always_comb begin
    fifo_v              = credits_used_q != '0;
    head                = order_q[rd_ptr_q];
    rsp_header_o        = {mem_rev_header_i, mem_rev_header_i};
    rsp_data_o          = {mem_rev_data_i, mem_rev_data_i};
    rsp_v_o             = 2'b00;
    rsp_v_o[head]       = reset_n_i & mem_rev_v_i & fifo_v;
    mem_rev_ready_and_o = reset_n_i & fifo_v & rsp_ready_and_i[head];
    rev_hs              = mem_rev_v_i & mem_rev_ready_and_o;
    rev_last            = rev_cnt_q == last_beat(mem_rev_header_i[rev_size_lsb_p +: 3]);
    complete            = rev_hs & rev_last;
    rev_cnt_d           = rev_cnt_q;
    if (rev_hs) rev_cnt_d = rev_last ? '0 : rev_cnt_q + 5'd1;
    credits_used_d = credits_used_q;
    if (grant & ~complete) credits_used_d = credits_used_q + CW'(1);
    if (~grant & complete) credits_used_d = credits_used_q - CW'(1);
    wr_ptr_d = wr_ptr_q;
    if (grant) wr_ptr_d = (wr_ptr_q == PW'(credits_p - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (complete) rd_ptr_d = (rd_ptr_q == PW'(credits_p - 1)) ? '0 : rd_ptr_q + PW'(1);
    busy_o = (state_q == LOCK) | fifo_v;
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n_i) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      rr_ptr_q       <= 1'b0;
      fwd_cnt_q      <= '0;
      rev_cnt_q      <= '0;
      credits_used_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      fwd_cnt_q      <= fwd_cnt_d;
      rev_cnt_q      <= rev_cnt_d;
      credits_used_q <= credits_used_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
    end
  end

  // Order FIFO storage: records which requester each granted message came from.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; the occupancy count (credits_used_q) alone decides validity.
    if (grant) order_q[wr_ptr_q] <= winner;
  end

`ifndef SYNTHESIS
  // A reverse beat with nothing outstanding means the memory side is out of step.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(mem_rev_v_i && !fifo_v))
        else $error("reverse beat arrived with no outstanding forward message");
    end
  end
`endif

endmodule
